// File: rtl/activations_pkg.sv
// Shared types and constants for the activation unit.
// Shift amounts set the hard-sigmoid slope (1/4) and the leaky slope (1/8).
package activations_pkg;

    typedef enum logic [1:0] {
        ACT_IDENTITY = 2'd0,
        ACT_RELU     = 2'd1,
        ACT_HSIGMOID = 2'd2,
        ACT_HTANH    = 2'd3
    } act_sel_t;

    localparam int unsigned HSIG_SHIFT  = 2;
    localparam int unsigned LEAKY_SHIFT = 3;

endpackage

// File: rtl/activations_lane.sv
// Single-lane combinational activation; no state, zero latency.
// Optional macro ACT_LEAKY_RELU_EN turns the RELU code into a leaky ReLU (slope 1/8).
module activation_lane
    import activations_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int S          = 7
) (
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  act_sel_t                     sel_i,
    output logic signed [DATA_WIDTH-1:0] y_o
);

    localparam logic signed [DATA_WIDTH-1:0] ONE     = DATA_WIDTH'(1) << S;
    localparam logic signed [DATA_WIDTH-1:0] NEG_ONE = -ONE;
    localparam logic signed [DATA_WIDTH:0]   ONE_W   = (DATA_WIDTH+1)'(1) << S;
    localparam logic signed [DATA_WIDTH:0]   HALF_W  = (DATA_WIDTH+1)'(1) << (S-1);

    // One extra bit keeps (x >>> 2) + HALF from wrapping at the positive extreme.
    logic signed [DATA_WIDTH:0] x_ext;
    logic signed [DATA_WIDTH:0] t;

    assign x_ext = {x_i[DATA_WIDTH-1], x_i};
    assign t     = (x_ext >>> HSIG_SHIFT) + HALF_W;

    always_comb begin
        y_o = x_i;
        case (sel_i)
            ACT_IDENTITY: y_o = x_i;
            ACT_RELU: begin
`ifdef ACT_LEAKY_RELU_EN
                if (x_i < 0) y_o = x_i >>> LEAKY_SHIFT;
`else
                if (x_i < 0) y_o = '0;
`endif
            end
            ACT_HSIGMOID: begin
                if (t < 0)          y_o = '0;
                else if (t > ONE_W) y_o = ONE;
                else                y_o = t[DATA_WIDTH-1:0];
            end
            ACT_HTANH: begin
                if (x_i > ONE)          y_o = ONE;
                else if (x_i < NEG_ONE) y_o = NEG_ONE;
            end
            default: y_o = x_i;
        endcase
    end

endmodule

// File: rtl/activations.sv
// Vector activation unit: SA_LENGTH parallel lanes, result registered (1-cycle latency).
// No back-pressure; en gates capture, rst (sync, active-high) wins over en. Macro: ACT_LEAKY_RELU_EN.
module activations
    import activations_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int SA_LENGTH  = 8,
    parameter int S          = 7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  act_sel_t                     sel,
    input  logic signed [DATA_WIDTH-1:0] in  [SA_LENGTH],
    output logic signed [DATA_WIDTH-1:0] out [SA_LENGTH]
);

    logic signed [DATA_WIDTH-1:0] out_d [SA_LENGTH];
    logic signed [DATA_WIDTH-1:0] out_q [SA_LENGTH];

    for (genvar g = 0; g < SA_LENGTH; g++) begin : g_lane
        activation_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .S          (S)
        ) u_lane (
            .x_i   (in[g]),
            .sel_i (sel),
            .y_o   (out_d[g])
        );
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SA_LENGTH; i++) begin
            if (rst)     out_q[i] <= '0;
            else if (en) out_q[i] <= out_d[i];
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_activations.sv
// Directed bench for activations: reset, each select code, hold, and reset priority.
module tb_activations;
    import activations_pkg::*;

    localparam int DW = 12;
    localparam int N  = 8;

    typedef logic signed [DW-1:0] vec_t [N];

    logic     clk = 1'b0;
    logic     rst;
    logic     en;
    act_sel_t sel;
    vec_t     in;
    vec_t     out;

    int total = 0;
    int bad   = 0;

    activations #(.DATA_WIDTH(DW), .SA_LENGTH(N), .S(7)) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .sel (sel),
        .in  (in),
        .out (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input vec_t e);
        for (int i = 0; i < N; i++) begin
            total++;
            assert (out[i] === e[i]) else begin
                bad++;
                $error("FAIL %s lane %0d got %0d expected %0d", tag, i, out[i], e[i]);
            end
        end
    endtask

    // Drive inputs, take one clock edge, sample 1 time unit later.
    task automatic step(input logic r, input logic e, input act_sel_t s, input vec_t v);
        rst = r;
        en  = e;
        sel = s;
        in  = v;
        @(posedge clk);
        #1;
    endtask

    vec_t v_base, v_alt, e_zero, e_id, e_relu, e_hsig, e_htanh, e_alt_id;

    initial begin
        v_base   = '{0, 400, 517, -512, -1, -2048, 2047, 52};
        v_alt    = '{5, -7, 100, 300, -300, 1, -129, 127};
        e_zero   = '{0, 0, 0, 0, 0, 0, 0, 0};
        e_id     = '{0, 400, 517, -512, -1, -2048, 2047, 52};
`ifdef ACT_LEAKY_RELU_EN
        e_relu   = '{0, 400, 517, -64, -1, -256, 2047, 52};
`else
        e_relu   = '{0, 400, 517, 0, 0, 0, 2047, 52};
`endif
        e_hsig   = '{64, 128, 128, 0, 63, 0, 128, 77};
        e_htanh  = '{0, 128, 128, -128, -1, -128, 128, 52};
        e_alt_id = '{5, -7, 100, 300, -300, 1, -129, 127};

        step(1'b1, 1'b0, ACT_IDENTITY, v_base);
        check("reset", e_zero);
        step(1'b1, 1'b1, ACT_IDENTITY, v_base);
        check("reset_over_en", e_zero);

        step(1'b0, 1'b1, ACT_IDENTITY, v_base);
        check("identity", e_id);
        step(1'b0, 1'b1, ACT_RELU, v_base);
        check("relu", e_relu);
        step(1'b0, 1'b1, ACT_HSIGMOID, v_base);
        check("hsigmoid", e_hsig);
        step(1'b0, 1'b1, ACT_HTANH, v_base);
        check("htanh", e_htanh);

        step(1'b0, 1'b1, ACT_IDENTITY, v_base);
        check("identity_again", e_id);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, ACT_RELU, v_alt);
            check("hold", e_id);
        end
        step(1'b0, 1'b1, ACT_IDENTITY, v_alt);
        check("identity_alt", e_alt_id);

        step(1'b1, 1'b1, ACT_HTANH, v_base);
        check("reset_late", e_zero);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/activations.md
Name: activations

Overview:
- Vector activation-function unit placed at the output of the systolic array (SA).
- Applies one of four element-wise activations to SA_LENGTH signed fixed-point lanes in parallel.
- Format is two's complement with S fractional bits, so 1.0 = 2^S.
- Result is registered: one-cycle latency, gated by an enable.

Parameters:
- DATA_WIDTH, 12, bit width of every lane, signed.
- SA_LENGTH, 8, number of lanes (SA row length).
- S, 7, fractional bits; legal range 1 <= S <= DATA_WIDTH-2, so +1.0 is representable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  capture enable.
- sel  input  2  activation select (act_sel_t).
- in  input  SA_LENGTH x DATA_WIDTH signed  input lanes, unpacked array [SA_LENGTH].
- out  output  SA_LENGTH x DATA_WIDTH signed  registered result lanes, unpacked array [SA_LENGTH].

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: on a posedge with rst=1, every out lane becomes 0. rst has priority over en.
- Capture: on a posedge with rst=0 and en=1, out[i] <= f_sel(in[i]) for all i.
- Hold: with en=0, out holds its value; sel and in are ignored.
- Latency: exactly 1 cycle. There is no handshake and no back-pressure; a new vector can be accepted every cycle.
- The per-lane function is purely combinational. Lanes are independent.
- ONE = 1 << S; HALF = 1 << (S-1).
- sel=2'b00 IDENTITY: y = x.
- sel=2'b01 RELU: y = (x < 0) ? 0 : x.
- sel=2'b10 HARD_SIGMOID: t = (x >>> 2) + HALF, evaluated in DATA_WIDTH+1 bits; y = clamp(t, 0, ONE).
  - >>> is an arithmetic shift (floor), e.g. -1 >>> 2 = -1.
- sel=2'b11 HARD_TANH: y = clamp(x, -ONE, ONE).
- Boundaries: most-negative input (-2^(DATA_WIDTH-1)) and max-positive input must not overflow any intermediate value. Every result fits DATA_WIDTH bits; no wrap-around.
- sel changing in the same cycle as data: the value of sel sampled at the capture edge applies.

Optional Feature:
- Macro: ACT_LEAKY_RELU_EN.
- Defined: sel=01 negative inputs produce x >>> 3 (arithmetic, floor) instead of 0; non-negative inputs pass unchanged.
- Undefined: plain ReLU exactly as specified above.
- All other sel codes are identical in both builds.

Decomposition:
- Package activations_pkg holds:
  - typedef enum logic [1:0] act_sel_t {ACT_IDENTITY=0, ACT_RELU=1, ACT_HSIGMOID=2, ACT_HTANH=3};
  - a shift constant for the hard-sigmoid slope (2);
  - a shift constant for the leaky slope (3).
- One sub-module, activation_lane (params DATA_WIDTH, S): combinational single-lane function. Instantiate it SA_LENGTH times via generate.
- The top level owns the output register, reset and enable.

Test Plan (defaults; in = {0, 400, 517, -512, -1, -2048, 2047, 52}, lane 0 first; en=1):
- Reset: hold rst=1 for one edge, then check out = all 0. Also hold rst=1 with en=1 and check out stays 0.
- sel=00 -> after one edge, out = {0, 400, 517, -512, -1, -2048, 2047, 52}.
- sel=01 -> out = {0, 400, 517, 0, 0, 0, 2047, 52}.
  - With ACT_LEAKY_RELU_EN: out = {0, 400, 517, -64, -1, -256, 2047, 52}.
- sel=10 -> out = {64, 128, 128, 0, 63, 0, 128, 77}.
- sel=11 -> out = {0, 128, 128, -128, -1, -128, 128, 52}.
- Hold: after sel=00 capture, drive en=0, sel=01 and change in -> out keeps the identity values for all following cycles until en returns to 1.
